// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// producers: grants, pulses transmit, tracks busy and reports frame completion.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic                 tx_transmit_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic [2:0]           owner_o,
    output logic                 error_o
);
    localparam int CMAX_PT = (PULSE_CYCLES > START_TIMEOUT) ? PULSE_CYCLES : START_TIMEOUT;
    localparam int CMAX    = (CMAX_PT > GAP_CYCLES) ? CMAX_PT : GAP_CYCLES;
    localparam int CW      = $clog2(CMAX + 1) + 1;
    localparam logic [CW-1:0] PULSE_N  = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_N    = CW'(GAP_CYCLES);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         owner_q, owner_d;
    logic [7:0]         data_q, data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               xmit_q, xmit_d;
    logic               err_q, err_d;

    logic               found;
    logic [2:0]         win;
    int                 rr_idx;
    logic [NUM_REQ-1:0] win_oh, owner_oh;
    logic [7:0]         win_data;
    logic [2:0]         nxt_ptr;

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ; first active request wins.
    always_comb begin
        found  = 1'b0;
        win    = ptr_q;
        rr_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = int'(ptr_q) + i;
            if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && k == rr_idx && req_i[k]) begin
                    found = 1'b1;
                    win   = 3'(k);
                end
            end
        end
    end

    always_comb begin
        win_oh   = '0;
        owner_oh = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            win_oh[k]   = (win == 3'(k));
            owner_oh[k] = (owner_q == 3'(k));
            if (win == 3'(k)) win_data = req_data_i[8*k +: 8];
        end
        nxt_ptr = (owner_q >= LAST_IDX) ? 3'd0 : owner_q + 3'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        ack_d   = '0;
        done_d  = '0;
        xmit_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (found && !tx_busy_i) begin
                    data_d  = win_data;
                    owner_d = win;
                    ack_d   = win_oh;
                    cnt_d   = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (cnt_q < PULSE_N) begin
                    xmit_d = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q >= TMO_LAST) begin
                    // Transmitter never started: abort this frame but keep serving.
                    err_d   = 1'b1;
                    done_d  = owner_oh;
                    ptr_d   = nxt_ptr;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    done_d  = owner_oh;
                    ptr_d   = nxt_ptr;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_N) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            xmit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            xmit_q  <= xmit_d;
            err_q   <= err_d;
        end
    end

    assign ack_o         = ack_q;
    assign done_o        = done_q;
    assign tx_transmit_o = xmit_q;
    assign tx_data_o     = data_q;
    assign owner_o       = owner_q;
    assign error_o       = err_q;
endmodule
